rgb2gray_ctrl: RTL and testbench

Frame-level sequencer for the free-running 3-stage RGB-to-luma converter in the plate-recognition front end. On a start pulse it walks the RGB frame buffer in raster order, presents one pixel per cycle to the converter, tracks each pixel through the fixed read and converter latencies, and writes the resulting 8-bit gray value to the gray frame buffer at the matching address. It sits between the capture frame buffer (BRAM, read port) and the gray buffer that feeds binarisation and plate location.

---
 rtl/rgb2gray_ctrl.sv | 150 +++++++++++++++
 tb/tb_rgb2gray_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2gray_ctrl.sv
// rgb2gray_ctrl: frame sequencer for a free-running 3-stage RGB-to-luma converter.
// Walks the RGB buffer in raster order, one read per cycle, and tracks each pixel
// through the read and converter latencies with a tag pipe so the gray value is
// written to the matching address. Validity comes only from the tag pipe.
module rgb2gray_ctrl #(
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned CONV_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_data,
    output logic [7:0]        conv_r,
    output logic [7:0]        conv_g,
    output logic [7:0]        conv_b,
    input  logic [7:0]        conv_y,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_line_end
);

    localparam int unsigned D     = RD_LAT + CONV_LAT;
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [D-1:0]      tag_vld_q, tag_vld_d;
    logic [D-1:0]      tag_le_q, tag_le_d;
    logic [ADDR_W-1:0] tag_addr_q [D];
    logic [ADDR_W-1:0] tag_addr_d [D];

    logic abort_take;
    logic last_read;
    logic pending;

    // Converter taps and write data are pure wiring.
    assign conv_r      = rd_data[23:16];
    assign conv_g      = rd_data[15:8];
    assign conv_b      = rd_data[7:0];
    assign wr_data     = conv_y;
    assign rd_addr     = rd_addr_q;
    assign wr_en       = tag_vld_q[D-1];
    assign wr_addr     = tag_addr_q[D-1];
    assign wr_line_end = tag_le_q[D-1];

    assign abort_take = abort && ((state_q == RUN) || (state_q == DRAIN));
    assign last_read  = (state_q == RUN) && (col_q == COL_LAST) && (row_q == ROW_LAST);
    // The tail stage is the write happening now; only earlier stages still owe writes.
    assign pending    = |tag_vld_q[D-2:0];

    // State, counters and tag pipe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            tag_vld_q <= '0;
            tag_le_q  <= '0;
            for (int unsigned i = 0; i < D; i++) tag_addr_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            col_q     <= col_d;
            row_q     <= row_d;
            tag_vld_q <= tag_vld_d;
            tag_le_q  <= tag_le_d;
            for (int unsigned i = 0; i < D; i++) tag_addr_q[i] <= tag_addr_d[i];
        end
    end

    // Next-state logic; start wins over abort in IDLE, abort cancels RUN/DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (abort)          state_d = IDLE;
                else if (last_read) state_d = DRAIN;
            end
            DRAIN: begin
                if (abort)         state_d = IDLE;
                else if (!pending) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy  = (state_q == RUN) || (state_q == DRAIN);
        done  = (state_q == DONE);
        rd_en = (state_q == RUN);
    end

    // Raster address/column/row counters; hold at the last pixel once it is read.
    always_comb begin
        rd_addr_d = rd_addr_q;
        col_d     = col_q;
        row_d     = row_q;
        if ((state_q == IDLE) && start) begin
            rd_addr_d = '0;
            col_d     = '0;
            row_d     = '0;
        end else if ((state_q == RUN) && !last_read) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q != ROW_LAST) row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Tag pipe: load the read issued this cycle, shift toward the write tail.
    always_comb begin
        tag_vld_d     = {tag_vld_q[D-2:0], rd_en};
        tag_le_d      = {tag_le_q[D-2:0], rd_en && (col_q == COL_LAST)};
        tag_addr_d[0] = rd_addr_q;
        for (int unsigned i = 1; i < D; i++) tag_addr_d[i] = tag_addr_q[i-1];
        if (abort_take) begin
            tag_vld_d = '0;
            tag_le_d  = '0;
        end
    end

endmodule

// File: tb/tb_rgb2gray_ctrl.sv
// Bench for rgb2gray_ctrl: two 4x2 instances (RD_LAT 1 and 2) share the command
// inputs; each has its own BRAM and 3-stage converter model and a scoreboard queue.
module tb_rgb2gray_ctrl;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = 19;
    localparam int D1 = 4;
    localparam int D2 = 5;

    typedef struct {
        logic [23:0] pix;
        logic [7:0]  gray;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          le;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, abort;
    int   cyc = 0;

    logic          busy1, done1, rd_en1, wr_en1, le1;
    logic [AW-1:0] rd_addr1, wr_addr1;
    logic [23:0]   rd_data1;
    logic [7:0]    r1, g1, b1, y1, wd1;
    logic          busy2, done2, rd_en2, wr_en2, le2;
    logic [AW-1:0] rd_addr2, wr_addr2;
    logic [23:0]   rd_data2;
    logic [7:0]    r2, g2, b2, y2, wd2;

    logic [23:0] mem [N];
    logic [7:0]  expg [N];
    vec_t        vecs [N];
    exp_t        q1[$];
    exp_t        q2[$];

    int total = 0;
    int bad   = 0;
    int first_wr1, last_wr1, wr_cnt1, done_cnt1, done_edge1;
    int first_wr2, wr_cnt2, done_cnt2, done_edge2;
    logic done_busy1;

    rgb2gray_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(1), .CONV_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .conv_r(r1), .conv_g(g1), .conv_b(b1), .conv_y(y1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wd1), .wr_line_end(le1)
    );

    rgb2gray_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(2), .CONV_LAT(3)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy2), .done(done2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .conv_r(r2), .conv_g(g2), .conv_b(b2), .conv_y(y2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wd2), .wr_line_end(le2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int s;
        s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
        return 8'(s >> 8);
    endfunction

    // Source BRAMs (latency 1 and 2) and free-running 3-stage converters.
    logic [23:0] s2a;
    logic [7:0]  c1a, c1b, c2a, c2b;
    always @(posedge clk) begin
        if (rd_en1) rd_data1 <= mem[rd_addr1[2:0]];
        if (rd_en2) s2a <= mem[rd_addr2[2:0]];
        rd_data2 <= s2a;
        c1a <= luma(r1, g1, b1); c1b <= c1a; y1 <= c1b;
        c2a <= luma(r2, g2, b2); c2b <= c2a; y2 <= c2b;
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard for the RD_LAT=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en1) begin
            wr_cnt1++;
            if (first_wr1 < 0) first_wr1 = cyc;
            last_wr1 = cyc;
            if (q1.size() == 0) check("wr1_spurious", wr_en1, 0);
            else begin
                e = q1.pop_front();
                check("wr1_addr", wr_addr1, e.addr);
                check("wr1_data", wd1, e.data);
                check("wr1_line_end", le1, e.le);
            end
        end
        if (done1) begin
            done_cnt1++;
            done_edge1 = cyc;
            done_busy1 = busy1;
        end
    end

    // Scoreboard for the RD_LAT=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en2) begin
            wr_cnt2++;
            if (first_wr2 < 0) first_wr2 = cyc;
            if (q2.size() == 0) check("wr2_spurious", wr_en2, 0);
            else begin
                e = q2.pop_front();
                check("wr2_addr", wr_addr2, e.addr);
                check("wr2_data", wd2, e.data);
                check("wr2_line_end", le2, e.le);
            end
        end
        if (done2) begin
            done_cnt2++;
            done_edge2 = cyc;
        end
    end

    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            exp_t e;
            e.addr = AW'(i);
            e.data = expg[i];
            e.le   = (i % W) == (W - 1);
            q1.push_back(e);
            q2.push_back(e);
        end
    endtask

    task automatic clear_track();
        first_wr1 = -1; last_wr1 = -1; wr_cnt1 = 0; done_cnt1 = 0; done_edge1 = -1; done_busy1 = 1'b1;
        first_wr2 = -1; wr_cnt2 = 0; done_cnt2 = 0; done_edge2 = -1;
    endtask

    // Start a frame; optionally re-pulse start at edge k+3 or abort at edge k+abort_at.
    task automatic run_frame(input int abort_at, input bit restart);
        int k;
        clear_track();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = cyc;
        check("start_rd_en", rd_en1, 1);
        check("start_rd_addr", rd_addr1, 0);
        check("start_busy", busy1, 1);
        for (int i = 1; i <= 20; i++) begin
            start = restart && (i == 3);
            abort = (abort_at == i);
            tick();
            if (abort_at == i) begin
                check("abort_busy1", busy1, 0);
                check("abort_rd_en1", rd_en1, 0);
                check("abort_busy2", busy2, 0);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (abort_at == 0) begin
            check("first_wr1_edge", first_wr1, k + D1);
            check("last_wr1_edge", last_wr1, k + N - 1 + D1);
            check("done1_edge", done_edge1, k + N + D1);
            check("done1_busy", done_busy1, 0);
            check("done1_count", done_cnt1, 1);
            check("wr1_count", wr_cnt1, N);
            check("first_wr2_edge", first_wr2, k + D2);
            check("done2_edge", done_edge2, k + N + D2);
            check("wr2_count", wr_cnt2, N);
            check("q1_left", q1.size(), 0);
            check("q2_left", q2.size(), 0);
            check("rd_addr_hold", rd_addr1, N - 1);
            check("idle_after_frame", busy1 | rd_en1 | done1, 0);
        end else begin
            check("abort_wr1_count", wr_cnt1, 0);
            check("abort_done1", done_cnt1, 0);
            check("abort_wr2_count", wr_cnt2, 0);
            check("abort_done2", done_cnt2, 0);
        end
    endtask

    initial begin
        vecs[0] = '{24'hFF0000, 8'd76};
        vecs[1] = '{24'h00FF00, 8'd149};
        vecs[2] = '{24'h0000FF, 8'd28};
        vecs[3] = '{24'h000000, 8'd0};
        vecs[4] = '{24'hFFFFFF, 8'd255};
        vecs[5] = '{24'h808080, 8'd128};
        vecs[6] = '{24'h010101, 8'd1};
        vecs[7] = '{24'h400000, 8'd19};
        clear_track();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_rd_en", rd_en1, 0);
        check("rst_wr_en", wr_en1, 0);
        check("rst_line_end", le1, 0);
        check("rst_rd_addr", rd_addr1, 0);
        check("rst_wr_addr", wr_addr1, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_quiet", busy1 | rd_en1 | wr_en1 | done1 | busy2 | wr_en2, 0);
        end

        // All-white frame.
        for (int i = 0; i < N; i++) begin mem[i] = 24'hFFFFFF; expg[i] = 8'hFF; end
        push_frame();
        run_frame(0, 1'b0);

        // Table of distinct pixels.
        for (int i = 0; i < N; i++) begin mem[i] = vecs[i].pix; expg[i] = vecs[i].gray; end
        push_frame();
        run_frame(0, 1'b0);

        // Second start while busy is ignored.
        push_frame();
        run_frame(0, 1'b1);

        // Abort three cycles after start, then a fresh full frame.
        run_frame(3, 1'b0);
        push_frame();
        run_frame(0, 1'b0);

        // Reset in the middle of a frame.
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        check("midrst_wr_en1", wr_en1, 0);
        check("midrst_wr_en2", wr_en2, 0);
        check("midrst_busy", busy1, 0);
        check("midrst_rd_en", rd_en1, 0);
        check("midrst_rd_addr", rd_addr1, 0);
        check("midrst_wr_addr", wr_addr1, 0);
        q1.delete();
        q2.delete();
        clear_track();
        rst = 1'b0;
        repeat (12) tick();
        check("midrst_no_wr1", wr_cnt1, 0);
        check("midrst_no_wr2", wr_cnt2, 0);
        check("midrst_no_done", done_cnt1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
